// File: rtl/instruction_fetcher_pkg.sv
// Shared CPU fetch-side definitions: fetch FSM state encodings and RAM timing,
// common with the memory arbiter.
package instruction_fetcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_READ = 3'd2,
        ST_FILL = 3'd3,
        ST_HIT  = 3'd4
    } fetch_state_t;

    localparam int unsigned RAM_RD_LAT = 1;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);
    // Capture index after which memAddr no longer needs to step ahead.
    localparam logic [1:0] STEP_LAST = 2'(WORD_BYTES - 1 - RAM_RD_LAT);

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetcher.sv
// Instruction fetch unit: single-cycle cache hits, byte-serial RAM refill on a miss
// with a same-cycle cache fill and instruction delivery.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter logic [31:0] INIT_PC = 32'h0
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        rdyIn,
    input  logic [31:0] pcIn,
    input  logic        pcValid,
    input  logic        flushIn,
    output logic        busy,
    output logic [31:0] instOut,
    output logic        instValid,
    output logic [31:0] cacheAddr,
    input  logic        cacheHit,
    input  logic [31:0] cacheData,
    output logic        cacheWrEn,
    output logic [31:0] cacheWrData,
    output logic        memReq,
    input  logic        memGrant,
    output logic [31:0] memAddr,
    input  logic [7:0]  memByte
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc_q;
    logic [31:0]  word_q;
    logic [31:0]  addr_q;
    logic [1:0]   cnt_q;
    logic         accept;

    assign accept = (state == ST_IDLE) && pcValid && !flushIn;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = cacheHit ? ST_HIT : ST_WAIT;
            ST_WAIT: begin
                if (flushIn)       state_nxt = ST_IDLE;
                else if (memGrant) state_nxt = ST_READ;
            end
            ST_READ: begin
                if (flushIn)                 state_nxt = ST_IDLE;
                else if (cnt_q == LAST_BYTE) state_nxt = ST_FILL;
            end
            ST_FILL: state_nxt = ST_IDLE;
            ST_HIT:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        memReq      = (state == ST_WAIT) || (state == ST_READ);
        memAddr     = addr_q;
        cacheAddr   = (state == ST_IDLE) ? align_pc(pcIn) : pc_q;
        cacheWrData = word_q;
        instOut     = word_q;
        // Strobes are gated by reset too so a refill caught by reset never writes.
        cacheWrEn   = (state == ST_FILL) && rdyIn && rstIn;
        instValid   = ((state == ST_HIT) || (state == ST_FILL)) && rdyIn && rstIn && !flushIn;
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            state  <= ST_IDLE;
            pc_q   <= INIT_PC;
            word_q <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else if (rdyIn) begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pc_q <= align_pc(pcIn);
                        if (cacheHit) begin
                            word_q <= cacheData;
                        end else begin
                            addr_q <= align_pc(pcIn);
                            cnt_q  <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!flushIn && memGrant) begin
                        addr_q <= pc_q + 32'd1;
                        cnt_q  <= '0;
                    end
                end
                ST_READ: begin
                    if (!flushIn) begin
                        // memByte lags memAddr by RAM_RD_LAT, so the address runs ahead of the capture index.
                        word_q[{cnt_q, 3'b000} +: 8] <= memByte;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q < STEP_LAST)
                            addr_q <= pc_q + 32'(cnt_q) + 32'(RAM_RD_LAT + 1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instruction_fetcher.md
INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

Interface
REQ-001 Parameter: INIT_PC, default 32'h0, value of the last-fetched-PC register after reset.
REQ-002 Clocking SHALL be: one clock; reset is synchronous and active-low.
REQ-003 clkIn  input  1  sole clock; all state changes on its rising edge.
REQ-004 rstIn  input  1  synchronous active-low reset.
REQ-005 rdyIn  input  1  global ready; low freezes all state and suppresses all strobes.
REQ-006 pcIn  input  32  fetch address; bits [1:0] ignored and treated as 00.
REQ-007 pcValid  input  1  fetch request.
REQ-008 flushIn  input  1  abort any in-flight fetch.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 instOut  output  32  fetched instruction.
REQ-011 instValid  output  1  one-cycle pulse; instOut is valid while it is high.
REQ-012 cacheAddr  output  32  address to the instruction cache (lookup and fill share it).
REQ-013 cacheHit  input  1  cache hit for cacheAddr (combinational from the cache).
REQ-014 cacheData  input  32  cached word for cacheAddr.
REQ-015 cacheWrEn  output  1  cache fill strobe.
REQ-016 cacheWrData  output  32  word to be written into the cache.
REQ-017 memReq  output  1  request to the memory arbiter.
REQ-018 memGrant  input  1  arbiter grant; held high while memReq is high once granted.
REQ-019 memAddr  output  32  byte address to RAM.
REQ-020 memByte  input  8  RAM read data, valid one cycle after memAddr is presented.

Function
REQ-021 States SHALL be IDLE, WAIT, READ, FILL and HIT.
- IDLE: cacheAddr = {pcIn[31:2],2'b00}.
- All other states: cacheAddr = latched PC.
REQ-022 Request acceptance SHALL require IDLE && pcValid && !flushIn; the PC is latched on acceptance.
- cacheHit=1: latch cacheData, go to HIT.
- cacheHit=0: go to WAIT.
REQ-023 HIT SHALL assert instValid=1 for one cycle with instOut = latched word, then return to IDLE.
- Hit latency is 1 cycle from acceptance.
REQ-024 WAIT SHALL hold memReq=1 until memGrant=1; the grant cycle G is the first READ cycle.
REQ-025 READ SHALL drive memAddr = PC+0..PC+3 in cycles G..G+3.
- memByte is captured in cycles G+1..G+4, little-endian: byte k goes to word bits [8k+7:8k].
- memReq stays high through G+4.
REQ-026 FILL occurs at cycle G+5 and SHALL, in the same cycle:
- assert cacheWrEn=1 with cacheWrData = assembled word and cacheAddr = PC;
- assert instValid=1 with instOut = the same word;
- return to IDLE.
REQ-027 memReq SHALL be low in FILL, and no new request is accepted in FILL (busy=1).
REQ-028 flushIn=1 in WAIT or READ SHALL return to IDLE next cycle.
- memReq drops next cycle.
- No cacheWrEn or instValid for the aborted fetch.
REQ-029 flushIn=1 in HIT SHALL suppress instValid.
REQ-030 flushIn=1 in FILL SHALL suppress instValid while still performing the cache write (the data is correct).
REQ-031 flushIn together with pcValid in IDLE: flush wins and the request is not accepted.
REQ-032 rdyIn=0 SHALL hold state, byte counter and word register, and force cacheWrEn=0 and instValid=0.
- The memory side stalls under the same global rdyIn.
REQ-033 Byte counter is 2 bits; PC+k uses 32-bit wrap-around addition.

Reset
REQ-034 With rstIn=0 at a clock edge, the next state SHALL be:
- state IDLE, memReq=0, cacheWrEn=0, instValid=0;
- instOut=0, memAddr=0, byte counter=0;
- latched PC=INIT_PC.
REQ-035 Reset mid-refill SHALL abandon the refill with no cache write; reset overrides rdyIn and flushIn.

Structure
REQ-036 State encodings and the RAM read latency (1) SHALL be constants in the shared CPU defines file, common with the memory arbiter.
REQ-037 There are no sub-modules; the block is instantiated beside InstructionCache and drives that cache's address, write-enable and data ports directly.

Verification
REQ-038 Hit: cache preloaded with 0x00000013 at 0x100; pcValid with pcIn=0x100 -> instValid next cycle, instOut=0x00000013, memReq never high.
REQ-039 Miss: RAM bytes 13,05,00,00 at 0x200; grant immediate -> memAddr 0x200..0x203, cacheWrEn and instValid at G+5, word 0x00000513; a repeat fetch then hits.
REQ-040 Grant delay: memGrant withheld 7 cycles -> memAddr is not stepped before the grant; FILL occurs exactly at grant+5.
REQ-041 Flush at G+2 -> IDLE next cycle, memReq low, no cacheWrEn, no instValid; a following fetch of 0x300 completes normally.
REQ-042 Flush in FILL -> cacheWrEn=1 and instValid=0; a later fetch of the same PC hits.
REQ-043 rdyIn low 3 cycles mid-READ, then rstIn low mid-refill -> state is frozen and then resumed with the correct word; after reset IDLE is reached with all outputs 0 and no cache write.
